// File: rtl/conv1d_ctrl_regs_if.sv
// conv1d_ctrl_regs_if
//
// Single-beat host register bus for the conv1d control/status block.
// The host presents one request per cycle (no backpressure); the register
// unit answers exactly one cycle later with registered read data and an
// error flag.
//
// Signals:
//   req_valid_i  host request valid
//   req_write_i  1 = write, 0 = read
//   req_addr_i   byte address (ADDR_W bits)
//   req_wdata_i  write data (DATA_W bits)
//   rsp_valid_o  response valid, one cycle after the request
//   rsp_rdata_o  read data, 0 for writes and errored accesses
//   rsp_error_o  unmapped or unaligned access
//
// Modports:
//   master  host side (drives requests, receives responses)
//   slave   register unit side
interface conv1d_ctrl_regs_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req_valid_i;
    logic              req_write_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic              rsp_valid_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_error_o;

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        input  rsp_valid_o, rsp_rdata_o, rsp_error_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        output rsp_valid_o, rsp_rdata_o, rsp_error_o
    );
endinterface

// File: rtl/conv1d_ctrl_regs.sv
// conv1d_ctrl_regs
//
// Multi-channel control/status register unit for the conv1d accelerator
// cluster. The host starts channels through CONTROL, watches running/done
// in STATUS, enables the level interrupt through IRQ_EN and sees rejected
// starts (start while already running) in ERR.
//
// Register map (byte addresses, bit c = channel c):
//   0x00        CONTROL  write-only, reads 0; write 1 to start a channel
//   0x04        STATUS   [NUM_CH-1:0] running (RO), [16+:NUM_CH] done (W1C)
//   0x08        IRQ_EN   RW
//   0x0C        ERR      sticky, W1C
//   0x10+4*c    CYCLES   RO per-channel cycle counter
//
// Optional feature: define CONV1D_CYCLE_CNT_EN to build the saturating
// per-channel cycle counters. Without it the CYCLES addresses stay mapped
// and read as 0.
//
// Ports:
//   clk_i       clock
//   rst_ni      synchronous active-low reset
//   bus         register bus (slave modport of conv1d_ctrl_regs_if)
//   start_o     per-channel one-cycle start pulse
//   acc_done_i  per-channel completion pulse from the accelerator
//   irq_o       registered level interrupt
module conv1d_ctrl_regs #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    conv1d_ctrl_regs_if.slave       bus,
    output logic [NUM_CH-1:0]       start_o,
    input  logic [NUM_CH-1:0]       acc_done_i,
    output logic                    irq_o
);

    logic [NUM_CH-1:0] running;
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] err;
    logic [NUM_CH-1:0] irq_en;

    logic [31:0]       addr_ext;
    logic              sel_control;
    logic              sel_status;
    logic              sel_irq_en;
    logic              sel_err;
    logic              sel_cycles;
    logic              mapped;
    logic              req_rd;
    logic              req_wr;
    logic [DATA_W-1:0] cycles_rd;

    logic [NUM_CH-1:0] start_req;
    logic [NUM_CH-1:0] start_fire;
    logic [NUM_CH-1:0] start_rej;
    logic [NUM_CH-1:0] done_evt;
    logic [NUM_CH-1:0] done_clr;
    logic [NUM_CH-1:0] err_clr;
    logic [NUM_CH-1:0] running_nxt;
    logic [NUM_CH-1:0] done_nxt;
    logic [NUM_CH-1:0] err_nxt;
    logic [DATA_W-1:0] rdata_nxt;

    // Only a handful of write-data bits land in registers; the rest are
    // deliberately ignored.
    logic              unused_wdata;
    assign unused_wdata = ^bus.req_wdata_i;

`ifdef CONV1D_CYCLE_CNT_EN
    logic [CNT_W-1:0]  cycles [NUM_CH];
`endif

    // Address decode. Comparing the full address against each register
    // offset also rejects unaligned addresses, since no register offset
    // has its low two bits set.
    always_comb begin
        addr_ext    = 32'(bus.req_addr_i);
        sel_control = (addr_ext == 32'h00);
        sel_status  = (addr_ext == 32'h04);
        sel_irq_en  = (addr_ext == 32'h08);
        sel_err     = (addr_ext == 32'h0C);
        sel_cycles  = 1'b0;
        cycles_rd   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (addr_ext == 32'(16 + 4 * c)) begin
                sel_cycles = 1'b1;
`ifdef CONV1D_CYCLE_CNT_EN
                cycles_rd[CNT_W-1:0] = cycles[c];
`endif
            end
        end
        mapped = sel_control | sel_status | sel_irq_en | sel_err | sel_cycles;
    end

    assign req_rd = bus.req_valid_i & ~bus.req_write_i & mapped;
    assign req_wr = bus.req_valid_i &  bus.req_write_i & mapped;

    // Channel state update. Starts and completions are judged against the
    // running flags as they stand this cycle, so a completion arriving in
    // the same cycle as a start request rejects that start. Sticky sets
    // are OR-ed in after the W1C clears so a set always wins.
    always_comb begin
        start_req = '0;
        done_clr  = '0;
        err_clr   = '0;
        if (req_wr && sel_control) start_req = bus.req_wdata_i[NUM_CH-1:0];
        if (req_wr && sel_status)  done_clr  = bus.req_wdata_i[16 +: NUM_CH];
        if (req_wr && sel_err)     err_clr   = bus.req_wdata_i[NUM_CH-1:0];

        start_fire  = start_req & ~running;
        start_rej   = start_req &  running;
        done_evt    = acc_done_i & running;

        running_nxt = (running & ~done_evt) | start_fire;
        done_nxt    = (done & ~done_clr & ~start_fire) | done_evt;
        err_nxt     = (err & ~err_clr) | start_rej;
    end

    // Read mux; returns state from before any same-cycle update.
    always_comb begin
        rdata_nxt = '0;
        if (req_rd) begin
            if (sel_status) begin
                rdata_nxt[NUM_CH-1:0]  = running;
                rdata_nxt[16 +: NUM_CH] = done;
            end else if (sel_irq_en) begin
                rdata_nxt[NUM_CH-1:0] = irq_en;
            end else if (sel_err) begin
                rdata_nxt[NUM_CH-1:0] = err;
            end else if (sel_cycles) begin
                rdata_nxt = cycles_rd;
            end
        end
    end

    // State, response and interrupt registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            running         <= '0;
            done            <= '0;
            err             <= '0;
            irq_en          <= '0;
            start_o         <= '0;
            irq_o           <= 1'b0;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_rdata_o <= '0;
            bus.rsp_error_o <= 1'b0;
        end else begin
            running         <= running_nxt;
            done            <= done_nxt;
            err             <= err_nxt;
            if (req_wr && sel_irq_en) irq_en <= bus.req_wdata_i[NUM_CH-1:0];
            start_o         <= start_fire;
            irq_o           <= |(done & irq_en);
            bus.rsp_valid_o <= bus.req_valid_i;
            bus.rsp_rdata_o <= rdata_nxt;
            bus.rsp_error_o <= bus.req_valid_i & ~mapped;
        end
    end

`ifdef CONV1D_CYCLE_CNT_EN
    // Cycle counters: zeroed on the start pulse, count every cycle the
    // channel is running (including the cycle its completion is sampled),
    // saturate instead of wrapping, and hold after completion.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (!rst_ni) begin
                cycles[c] <= '0;
            end else if (start_fire[c]) begin
                cycles[c] <= '0;
            end else if (running[c] && (cycles[c] != '1)) begin
                cycles[c] <= cycles[c] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv1d_ctrl_regs.sv
// tb_conv1d_ctrl_regs
//
// Testbench for conv1d_ctrl_regs. A directed vector table walks through
// reset, starts, completions, rejected starts, sticky flag clears, the
// interrupt path, error decoding and reset mid-operation. A randomized
// phase then compares the design cycle by cycle with a behavioural model
// that tracks channels as plain flags and derives cycle counts from the
// edges at which channels started and stopped.
module tb_conv1d_ctrl_regs;

    localparam int NUM_CH  = 4;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef CONV1D_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NUM_CH-1:0] start_o;
    logic [NUM_CH-1:0] acc_done_i = '0;
    logic              irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    conv1d_ctrl_regs_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    conv1d_ctrl_regs #(
        .NUM_CH(NUM_CH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .bus       (bus),
        .start_o   (start_o),
        .acc_done_i(acc_done_i),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model state
    bit m_running [NUM_CH];
    bit m_done    [NUM_CH];
    bit m_err     [NUM_CH];
    bit m_irq_en  [NUM_CH];
    int m_start_edge [NUM_CH];
    int m_stop_edge  [NUM_CH];
    int m_edge = 0;

    // Expected outputs for the cycle just applied
    bit          x_valid;
    logic [31:0] x_rdata;
    bit          x_error;
    logic [3:0]  x_start;
    bit          x_irq;

    typedef struct {
        bit          rst_n;
        bit          valid;
        bit          write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  acc_done;
        bit          e_valid;
        logic [31:0] e_rdata;
        bit          e_error;
        logic [3:0]  e_start;
        bit          e_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(bit rst_n, bit valid, bit write, logic [7:0] addr,
                                   logic [31:0] wdata, logic [3:0] acc_done,
                                   bit e_valid, logic [31:0] e_rdata, bit e_error,
                                   logic [3:0] e_start, bit e_irq);
        vec_t v;
        v.rst_n = rst_n; v.valid = valid; v.write = write; v.addr = addr;
        v.wdata = wdata; v.acc_done = acc_done;
        v.e_valid = e_valid; v.e_rdata = e_rdata; v.e_error = e_error;
        v.e_start = e_start; v.e_irq = e_irq;
        vecs.push_back(v);
    endfunction

    // Cycles a channel has been running as seen by a read this cycle:
    // from its start edge up to its stop edge, or up to the previous edge
    // if still running, saturated to the counter width.
    function automatic int cyclesNow(int c);
        int last;
        int v;
        last = m_running[c] ? (m_edge - 1) : m_stop_edge[c];
        v = last - m_start_edge[c];
        if (v > CNT_MAX) v = CNT_MAX;
        return CNT_EN ? v : 0;
    endfunction

    task automatic modelStep(input bit rst_n, input bit valid, input bit write,
                             input logic [7:0] addr, input logic [31:0] wdata,
                             input logic [3:0] acc_done);
        int a;
        bit mapped;
        bit was_running [NUM_CH];
        m_edge++;
        x_valid = 1'b0; x_rdata = '0; x_error = 1'b0; x_start = '0; x_irq = 1'b0;
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_running[c] = 1'b0; m_done[c] = 1'b0; m_err[c] = 1'b0; m_irq_en[c] = 1'b0;
                m_start_edge[c] = m_edge; m_stop_edge[c] = m_edge;
            end
            return;
        end
        for (int c = 0; c < NUM_CH; c++)
            if (m_done[c] && m_irq_en[c]) x_irq = 1'b1;
        a = int'(addr);
        mapped = (a % 4 == 0) && ((a <= 12) || (a >= 16 && a < 16 + 4 * NUM_CH));
        x_valid = valid;
        x_error = valid && !mapped;
        for (int c = 0; c < NUM_CH; c++) was_running[c] = m_running[c];
        if (valid && mapped && !write) begin
            if (a == 4) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    x_rdata[c]      = m_running[c];
                    x_rdata[16 + c] = m_done[c];
                end
            end else if (a == 8) begin
                for (int c = 0; c < NUM_CH; c++) x_rdata[c] = m_irq_en[c];
            end else if (a == 12) begin
                for (int c = 0; c < NUM_CH; c++) x_rdata[c] = m_err[c];
            end else if (a >= 16) begin
                x_rdata = 32'(cyclesNow((a - 16) / 4));
            end
        end
        if (valid && mapped && write) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (a == 0 && wdata[c]) begin
                    if (was_running[c]) begin
                        m_err[c] = 1'b1;
                    end else begin
                        x_start[c] = 1'b1;
                        m_running[c] = 1'b1;
                        m_done[c] = 1'b0;
                        m_start_edge[c] = m_edge;
                    end
                end
                if (a == 4 && wdata[16 + c]) m_done[c] = 1'b0;
                if (a == 8) m_irq_en[c] = wdata[c];
                if (a == 12 && wdata[c]) m_err[c] = 1'b0;
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (acc_done[c] && was_running[c]) begin
                m_running[c] = 1'b0;
                m_done[c] = 1'b1;
                m_stop_edge[c] = m_edge;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, then wait until just
    // after the clock edge that consumes them.
    task automatic applyStimulus(input bit rst_n, input bit valid, input bit write,
                                 input logic [7:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] acc_done);
        rst_ni          = rst_n;
        bus.req_valid_i = valid;
        bus.req_write_i = write;
        bus.req_addr_i  = addr;
        bus.req_wdata_i = wdata;
        acc_done_i      = acc_done;
        modelStep(rst_n, valid, write, addr, wdata, acc_done);
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input bit e_valid, input logic [31:0] e_rdata,
                               input bit e_error, input logic [3:0] e_start, input bit e_irq);
        n_checks += 5;
        if (bus.rsp_valid_o !== e_valid) begin
            n_fail++;
            $display("[TB] FAIL %s rsp_valid got %b expected %b", tag, bus.rsp_valid_o, e_valid);
        end
        if (bus.rsp_rdata_o !== e_rdata) begin
            n_fail++;
            $display("[TB] FAIL %s rsp_rdata got 0x%08h expected 0x%08h", tag, bus.rsp_rdata_o, e_rdata);
        end
        if (bus.rsp_error_o !== e_error) begin
            n_fail++;
            $display("[TB] FAIL %s rsp_error got %b expected %b", tag, bus.rsp_error_o, e_error);
        end
        if (start_o !== e_start) begin
            n_fail++;
            $display("[TB] FAIL %s start_o got 0x%h expected 0x%h", tag, start_o, e_start);
        end
        if (irq_o !== e_irq) begin
            n_fail++;
            $display("[TB] FAIL %s irq_o got %b expected %b", tag, irq_o, e_irq);
        end
    endtask

    initial begin
        logic [31:0] cyc2_exp;
        logic [31:0] cyc0_exp;
        cyc2_exp = CNT_EN ? 32'd15 : 32'd0;
        cyc0_exp = CNT_EN ? 32'd1  : 32'd0;

        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;

        //      rst v  w  addr   wdata          done  | v  rdata          err start irq
        addVec(0, 0, 0, 8'h00, 32'h0,          4'h0,   0, 32'h0,          0, 4'h0, 0);
        addVec(1, 1, 0, 8'h04, 32'h0,          4'h0,   1, 32'h0,          0, 4'h0, 0);
        addVec(1, 1, 0, 8'h08, 32'h0,          4'h0,   1, 32'h0,          0, 4'h0, 0);
        addVec(1, 1, 0, 8'h0C, 32'h0,          4'h0,   1, 32'h0,          0, 4'h0, 0);
        addVec(1, 1, 1, 8'h00, 32'h5,          4'h0,   1, 32'h0,          0, 4'h5, 0);
        addVec(1, 1, 0, 8'h04, 32'h0,          4'h0,   1, 32'h5,          0, 4'h0, 0);
        addVec(1, 0, 0, 8'h00, 32'h0,          4'h1,   0, 32'h0,          0, 4'h0, 0);
        addVec(1, 1, 0, 8'h04, 32'h0,          4'h0,   1, 32'h00010004,   0, 4'h0, 0);
        addVec(1, 1, 1, 8'h00, 32'h2,          4'h0,   1, 32'h0,          0, 4'h2, 0);
        addVec(1, 1, 1, 8'h00, 32'h2,          4'h0,   1, 32'h0,          0, 4'h0, 0);
        addVec(1, 1, 0, 8'h0C, 32'h0,          4'h0,   1, 32'h2,          0, 4'h0, 0);
        addVec(1, 1, 1, 8'h0C, 32'h2,          4'h0,   1, 32'h0,          0, 4'h0, 0);
        addVec(1, 1, 0, 8'h0C, 32'h0,          4'h0,   1, 32'h0,          0, 4'h0, 0);
        addVec(1, 1, 1, 8'h08, 32'h1,          4'h0,   1, 32'h0,          0, 4'h0, 0);
        addVec(1, 1, 0, 8'h08, 32'h0,          4'h0,   1, 32'h1,          0, 4'h0, 1);
        addVec(1, 1, 1, 8'h04, 32'h00010000,   4'h0,   1, 32'h0,          0, 4'h0, 1);
        addVec(1, 0, 0, 8'h00, 32'h0,          4'h0,   0, 32'h0,          0, 4'h0, 0);
        addVec(1, 1, 1, 8'h00, 32'h1,          4'h0,   1, 32'h0,          0, 4'h1, 0);
        addVec(1, 1, 1, 8'h04, 32'h00010000,   4'h1,   1, 32'h0,          0, 4'h0, 0);
        addVec(1, 1, 0, 8'h04, 32'h0,          4'h0,   1, 32'h00010006,   0, 4'h0, 1);
        addVec(1, 0, 0, 8'h00, 32'h0,          4'h6,   0, 32'h0,          0, 4'h0, 1);
        addVec(1, 1, 0, 8'h02, 32'h0,          4'h0,   1, 32'h0,          1, 4'h0, 1);
        addVec(1, 1, 0, 8'h80, 32'h0,          4'h0,   1, 32'h0,          1, 4'h0, 1);
        addVec(1, 1, 1, 8'h06, 32'hFFFFFFFF,   4'h0,   1, 32'h0,          1, 4'h0, 1);
        addVec(1, 1, 0, 8'h04, 32'h0,          4'h0,   1, 32'h00070000,   0, 4'h0, 1);
        addVec(1, 1, 0, 8'h18, 32'h0,          4'h0,   1, cyc2_exp,       0, 4'h0, 1);
        addVec(1, 1, 0, 8'h10, 32'h0,          4'h0,   1, cyc0_exp,       0, 4'h0, 1);
        addVec(1, 1, 0, 8'h1C, 32'h0,          4'h0,   1, 32'h0,          0, 4'h0, 1);
        addVec(1, 1, 0, 8'h20, 32'h0,          4'h0,   1, 32'h0,          1, 4'h0, 1);
        addVec(1, 1, 0, 8'h00, 32'h0,          4'h0,   1, 32'h0,          0, 4'h0, 1);
        addVec(1, 1, 1, 8'h00, 32'h2,          4'h0,   1, 32'h0,          0, 4'h2, 1);
        addVec(1, 1, 1, 8'h00, 32'h2,          4'h2,   1, 32'h0,          0, 4'h0, 1);
        addVec(1, 1, 0, 8'h0C, 32'h0,          4'h0,   1, 32'h2,          0, 4'h0, 1);
        addVec(1, 1, 0, 8'h04, 32'h0,          4'h0,   1, 32'h00070000,   0, 4'h0, 1);
        addVec(1, 1, 1, 8'h08, 32'hFFFFFFFF,   4'h0,   1, 32'h0,          0, 4'h0, 1);
        addVec(1, 1, 0, 8'h08, 32'h0,          4'h0,   1, 32'hF,          0, 4'h0, 1);
        addVec(1, 1, 1, 8'h04, 32'hFFFFFFFF,   4'h0,   1, 32'h0,          0, 4'h0, 1);
        addVec(1, 0, 0, 8'h00, 32'h0,          4'h0,   0, 32'h0,          0, 4'h0, 0);
        addVec(1, 0, 0, 8'h00, 32'h0,          4'hF,   0, 32'h0,          0, 4'h0, 0);
        addVec(1, 1, 0, 8'h04, 32'h0,          4'h0,   1, 32'h0,          0, 4'h0, 0);
        addVec(1, 1, 1, 8'h00, 32'h8,          4'h0,   1, 32'h0,          0, 4'h8, 0);
        addVec(0, 1, 0, 8'h04, 32'h0,          4'h0,   0, 32'h0,          0, 4'h0, 0);
        addVec(1, 0, 0, 8'h00, 32'h0,          4'h8,   0, 32'h0,          0, 4'h0, 0);
        addVec(1, 1, 0, 8'h04, 32'h0,          4'h0,   1, 32'h0,          0, 4'h0, 0);
        addVec(1, 1, 0, 8'h08, 32'h0,          4'h0,   1, 32'h0,          0, 4'h0, 0);

        $display("[TB] directed table: %0d vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].valid, vecs[i].write, vecs[i].addr,
                          vecs[i].wdata, vecs[i].acc_done);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_rdata,
                        vecs[i].e_error, vecs[i].e_start, vecs[i].e_irq);
        end

        // Long run to saturate a counter and read it back mid-run and after.
        applyStimulus(1, 1, 1, 8'h00, 32'h4, 4'h0);
        checkOutput("sat_start", x_valid, x_rdata, x_error, x_start, x_irq);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 0, 0, 8'h00, 32'h0, (i == 19) ? 4'h4 : 4'h0);
            checkOutput("sat_run", x_valid, x_rdata, x_error, x_start, x_irq);
        end
        applyStimulus(1, 1, 0, 8'h18, 32'h0, 4'h0);
        checkOutput("sat_read", x_valid, x_rdata, x_error, x_start, x_irq);

        $display("[TB] randomized phase");
        for (int i = 0; i < 1500; i++) begin
            bit          r_rst_n;
            bit          r_valid;
            bit          r_write;
            logic [7:0]  r_addr;
            logic [31:0] r_wdata;
            logic [3:0]  r_done;
            r_rst_n = ($urandom_range(0, 99) != 0);
            r_valid = ($urandom_range(0, 9) < 7);
            r_write = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 11))
                0, 1:    r_addr = 8'h00;
                2, 3:    r_addr = 8'h04;
                4:       r_addr = 8'h08;
                5:       r_addr = 8'h0C;
                6:       r_addr = 8'h10;
                7:       r_addr = 8'h14;
                8:       r_addr = 8'h18;
                9:       r_addr = 8'h1C;
                10:      r_addr = 8'h20;
                default: r_addr = 8'($urandom);
            endcase
            r_wdata = $urandom;
            for (int c = 0; c < NUM_CH; c++) r_done[c] = ($urandom_range(0, 5) == 0);
            applyStimulus(r_rst_n, r_valid, r_write, r_addr, r_wdata, r_done);
            checkOutput($sformatf("rand%0d", i), x_valid, x_rdata, x_error, x_start, x_irq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
